key_loader: RTL and testbench

Parametrised word-serial key assembler. It accepts `NUM_WORDS` words of `WORD_W` bits over a valid/ready stream, checks the frame framing, and presents the assembled key to the hash core through a valid/ready output handshake. It sits between the host word source and the Skein core's key input. An optional shadow buffer lets the next key load while the core still holds the current one.

---
 rtl/key_loader_pkg.sv | 18 +
 rtl/key_loader_fill.sv | 69 ++++++
 rtl/key_loader.sv | 131 +++++++++++++
 tb/tb_key_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_loader_pkg.sv
// Shared definitions for the key_loader word-serial key assembler:
// default geometry, fill-state encoding and the index-width helper.
package key_loader_pkg;

    localparam int DEFAULT_WORD_W    = 64;
    localparam int DEFAULT_NUM_WORDS = 16;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_e;

    // Width of the word-slot index; never narrower than one bit.
    function automatic int idx_w(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/key_loader_fill.sv
// Word-slot index counter, frame check and key assembly register for key_loader.
// complete is combinational on the accepting edge; frame_err is a registered pulse.
module key_loader_fill
    import key_loader_pkg::*;
#(
    parameter int WORD_W    = DEFAULT_WORD_W,
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    input  logic                          accept,
    input  logic [WORD_W-1:0]             word,
    input  logic                          word_last,
    output logic [WORD_W*NUM_WORDS-1:0]   fill_key,
    output logic [idx_w(NUM_WORDS)-1:0]   fill_idx,
    output logic                          complete,
    output logic                          frame_err
);

    localparam int KEY_W = WORD_W * NUM_WORDS;
    localparam int IDX_W = idx_w(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    logic [IDX_W-1:0] idx_q;
    logic [KEY_W-1:0] fill_q;
    logic             err_q;

    logic take;
    logic at_last;
    logic bad_frame;

    // A word that arrives together with clear is dropped and cannot raise an error.
    always_comb begin
        take      = accept && !clear;
        at_last   = (idx_q == LAST_IDX);
        complete  = take && at_last && word_last;
        bad_frame = take && (at_last != word_last);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: the wide assembly register is reset too, because it is directly
    // visible on key_o in the single-register build and must read zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            fill_q <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= bad_frame;
            if (clear) begin
                idx_q <= '0;
            end else if (take) begin
                for (int k = 0; k < NUM_WORDS; k++) begin
                    if (idx_q == IDX_W'(k)) begin
                        fill_q[k*WORD_W +: WORD_W] <= word;
                    end
                end
                idx_q <= (at_last || word_last) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign fill_key  = fill_q;
    assign fill_idx  = idx_q;
    assign frame_err = err_q;

endmodule

// File: rtl/key_loader.sv
// key_loader top: assembles NUM_WORDS words into one key and hands it out over valid/ready.
// Define KEY_LOADER_DBUF_EN for a separate fill buffer so loading overlaps a held key.
module key_loader
    import key_loader_pkg::*;
#(
    parameter int WORD_W    = DEFAULT_WORD_W,
    parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clear_i,
    input  logic                          word_valid_i,
    input  logic [WORD_W-1:0]             word_i,
    input  logic                          word_last_i,
    output logic                          word_ready_o,
    output logic                          key_valid_o,
    input  logic                          key_ready_i,
    output logic [WORD_W*NUM_WORDS-1:0]   key_o,
    output logic [idx_w(NUM_WORDS)-1:0]   fill_idx_o,
    output logic                          frame_err_o
);

    localparam int KEY_W = WORD_W * NUM_WORDS;

    logic             accept;
    logic             complete;
    logic [KEY_W-1:0] fill_key;
    logic             key_valid_q;

    assign accept      = word_valid_i && word_ready_o;
    assign key_valid_o = key_valid_q;

    key_loader_fill #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_fill (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .clear     (clear_i),
        .accept    (accept),
        .word      (word_i),
        .word_last (word_last_i),
        .fill_key  (fill_key),
        .fill_idx  (fill_idx_o),
        .complete  (complete),
        .frame_err (frame_err_o)
    );

`ifdef KEY_LOADER_DBUF_EN

    fill_state_e      state_q;
    fill_state_e      state_d;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] key_d;
    logic             key_valid_d;
    logic             out_free;
    logic [KEY_W-1:0] assembled;

    assign word_ready_o = (state_q == FILL);
    assign out_free     = !key_valid_q || key_ready_i;
    // The last word is still in flight on the completing edge, so bypass it in.
    assign assembled    = {word_i, fill_key[KEY_W-WORD_W-1:0]};

    // NOTE: every combinational output gets a default first, so no path through
    // the case statement can leave a value unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        key_valid_d = key_valid_q && !key_ready_i;
        if (clear_i) begin
            state_d     = FILL;
            key_valid_d = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (complete) begin
                        if (out_free) begin
                            key_d       = assembled;
                            key_valid_d = 1'b1;
                        end else begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (out_free) begin
                        key_d       = fill_key;
                        key_valid_d = 1'b1;
                        state_d     = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= FILL;
            key_q       <= '0;
            key_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
        end
    end

    assign key_o = key_q;

`else

    // The assembly register doubles as the output register; input stalls while it is held.
    assign word_ready_o = !key_valid_q;
    assign key_o        = fill_key;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_valid_q <= 1'b0;
        end else if (clear_i) begin
            key_valid_q <= 1'b0;
        end else if (complete) begin
            key_valid_q <= 1'b1;
        end else if (key_ready_i) begin
            key_valid_q <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_key_loader.sv
// Scoreboard bench for key_loader: expected keys are queued as frames are driven
// and compared word by word when the DUT hands a key out.
module tb_key_loader;
    import key_loader_pkg::*;

    localparam int WORD_W    = 64;
    localparam int NUM_WORDS = 16;
    localparam int KEY_W     = WORD_W * NUM_WORDS;
    localparam int IDX_W     = idx_w(NUM_WORDS);

    logic              clk = 1'b0;
    logic              rst_n_i;
    logic              clear_i;
    logic              word_valid_i;
    logic [WORD_W-1:0] word_i;
    logic              word_last_i;
    logic              word_ready_o;
    logic              key_valid_o;
    logic              key_ready_i;
    logic [KEY_W-1:0]  key_o;
    logic [IDX_W-1:0]  fill_idx_o;
    logic              frame_err_o;

    always #5 clk = ~clk;

    key_loader #(
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .clear_i      (clear_i),
        .word_valid_i (word_valid_i),
        .word_i       (word_i),
        .word_last_i  (word_last_i),
        .word_ready_o (word_ready_o),
        .key_valid_o  (key_valid_o),
        .key_ready_i  (key_ready_i),
        .key_o        (key_o),
        .fill_idx_o   (fill_idx_o),
        .frame_err_o  (frame_err_o)
    );

    int               n_vec = 0;
    int               n_err = 0;
    int               err_pulses = 0;
    logic [KEY_W-1:0] exp_q[$];
    logic [KEY_W-1:0] mon_exp;
    logic [KEY_W-1:0] key_a;
    logic [KEY_W-1:0] key_b;
    logic [KEY_W-1:0] key_c;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] make_key(input logic [WORD_W-1:0] base);
        logic [KEY_W-1:0] r;
        for (int k = 0; k < NUM_WORDS; k++) r[k*WORD_W +: WORD_W] = base + WORD_W'(k);
        return r;
    endfunction

    // Output monitor: a transfer happens on the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (frame_err_o) err_pulses++;
        if (rst_n_i && key_valid_o && key_ready_i) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key", {63'b0, key_valid_o}, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                for (int w = 0; w < NUM_WORDS; w++)
                    check("key_word", key_o[w*WORD_W +: WORD_W], mon_exp[w*WORD_W +: WORD_W]);
            end
        end
    end

    task automatic send_word(input logic [WORD_W-1:0] w, input logic last);
        int t;
        t = 0;
        word_valid_i = 1'b1;
        word_i       = w;
        word_last_i  = last;
        @(negedge clk);
        while (!word_ready_o && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!word_ready_o) check("ready_timeout", {63'b0, word_ready_o}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [WORD_W-1:0] base, input int n, input int last_at);
        for (int k = 0; k < n; k++) send_word(base + WORD_W'(k), k == last_at);
        word_valid_i = 1'b0;
        word_last_i  = 1'b0;
    endtask

    task automatic good_frame(input logic [WORD_W-1:0] base);
        exp_q.push_back(make_key(base));
        send_frame(base, NUM_WORDS, NUM_WORDS - 1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n_i      = 1'b0;
        clear_i      = 1'b0;
        word_valid_i = 1'b0;
        word_i       = '0;
        word_last_i  = 1'b0;
        key_ready_i  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n_i = 1'b1;
        @(negedge clk);
        check("rst_valid", {63'b0, key_valid_o}, 64'd0);
        check("rst_err", {63'b0, frame_err_o}, 64'd0);
        check("rst_idx", 64'(fill_idx_o), 64'd0);
        check("rst_ready", {63'b0, word_ready_o}, 64'd1);
        check("rst_key_zero", {63'b0, key_o == '0}, 64'd1);
        @(posedge clk);
        #1;

        // Basic frame 0x0..0xF with one-cycle latency
        good_frame(64'h0);
        @(negedge clk);
        check("latency_valid", {63'b0, key_valid_o}, 64'd1);
        check("key_lsw", key_o[63:0], 64'h0);
        check("key_msw", key_o[1023:960], 64'hF);
        check("basic_err", {63'b0, frame_err_o}, 64'd0);
        @(negedge clk);
        check("valid_cleared", {63'b0, key_valid_o}, 64'd0);
        check("ready_after_xfer", {63'b0, word_ready_o}, 64'd1);
        @(posedge clk);
        #1;

        // Early last on index 5, then a clean frame
        send_frame(64'h1100, 6, 5);
        @(negedge clk);
        check("early_err", {63'b0, frame_err_o}, 64'd1);
        check("early_idx", 64'(fill_idx_o), 64'd0);
        check("early_valid", {63'b0, key_valid_o}, 64'd0);
        @(negedge clk);
        check("early_err_pulse", {63'b0, frame_err_o}, 64'd0);
        @(posedge clk);
        #1;
        good_frame(64'h1000);

        // 16th word without last
        send_frame(64'h2000, NUM_WORDS, -1);
        @(negedge clk);
        check("missing_err", {63'b0, frame_err_o}, 64'd1);
        check("missing_idx", 64'(fill_idx_o), 64'd0);
        repeat (3) @(negedge clk);
        check("missing_no_key", {63'b0, key_valid_o}, 64'd0);
        check("err_pulse_count", err_pulses, 2);
        @(posedge clk);
        #1;

        // Consumer stall for about 40 cycles with input pending
        drain();
        key_ready_i = 1'b0;
        key_a = make_key(64'h3000);
        key_b = make_key(64'h4000);
        good_frame(64'h3000);
`ifdef KEY_LOADER_DBUF_EN
        good_frame(64'h4000);
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("stall_ready_full", {63'b0, word_ready_o}, 64'd0);
            check("stall_hold", {63'b0, key_o == key_a}, 64'd1);
            check("stall_valid", {63'b0, key_valid_o}, 64'd1);
        end
        @(posedge clk);
        #1 key_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("dbuf_next_valid", {63'b0, key_valid_o}, 64'd1);
        check("dbuf_next_key", {63'b0, key_o == key_b}, 64'd1);
        check("dbuf_ready_back", {63'b0, word_ready_o}, 64'd1);
        @(posedge clk);
        #1;
`else
        word_valid_i = 1'b1;
        word_i       = 64'h4000;
        word_last_i  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("stall_ready", {63'b0, word_ready_o}, 64'd0);
            check("stall_hold", {63'b0, key_o == key_a}, 64'd1);
            check("stall_valid", {63'b0, key_valid_o}, 64'd1);
        end
        @(posedge clk);
        #1 key_ready_i = 1'b1;
        good_frame(64'h4000);
`endif

        // Clear coincident with word 8
        drain();
        send_frame(64'h5000, 8, -1);
        word_valid_i = 1'b1;
        word_i       = 64'h5008;
        clear_i      = 1'b1;
        @(posedge clk);
        #1;
        clear_i      = 1'b0;
        word_valid_i = 1'b0;
        @(negedge clk);
        check("clear_idx", 64'(fill_idx_o), 64'd0);
        check("clear_err", {63'b0, frame_err_o}, 64'd0);
        check("clear_valid", {63'b0, key_valid_o}, 64'd0);
        @(negedge clk);
        check("clear_no_err", {63'b0, frame_err_o}, 64'd0);
        @(posedge clk);
        #1;
        good_frame(64'h6000);

        // Clear while a key is held: valid drops, key_o keeps its value
        drain();
        key_ready_i = 1'b0;
        key_c = make_key(64'h7000);
        good_frame(64'h7000);
        @(negedge clk);
        check("held_valid", {63'b0, key_valid_o}, 64'd1);
        @(posedge clk);
        #1 clear_i = 1'b1;
        @(posedge clk);
        #1 clear_i = 1'b0;
        @(negedge clk);
        check("clear_drops_valid", {63'b0, key_valid_o}, 64'd0);
        check("clear_keeps_key", {63'b0, key_o == key_c}, 64'd1);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 key_ready_i = 1'b1;

        // Reset mid-fill
        send_frame(64'h8000, 5, -1);
        @(posedge clk);
        #3 rst_n_i = 1'b0;
        #1;
        check("rst_fill_idx", 64'(fill_idx_o), 64'd0);
        check("rst_fill_err", {63'b0, frame_err_o}, 64'd0);
        check("rst_fill_valid", {63'b0, key_valid_o}, 64'd0);
        check("rst_fill_key", {63'b0, key_o == '0}, 64'd1);
        @(posedge clk);
        #1 rst_n_i = 1'b1;
        @(negedge clk);
        check("rst_fill_ready", {63'b0, word_ready_o}, 64'd1);
        @(posedge clk);
        #1;

        // Reset while a key is held
        key_ready_i = 1'b0;
        good_frame(64'h9000);
        @(negedge clk);
        check("pre_rst_valid", {63'b0, key_valid_o}, 64'd1);
        #2 rst_n_i = 1'b0;
        #1;
        check("rst_held_valid", {63'b0, key_valid_o}, 64'd0);
        check("rst_held_key", {63'b0, key_o == '0}, 64'd1);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_n_i     = 1'b1;
        key_ready_i = 1'b1;
        @(negedge clk);
        check("rst_held_ready", {63'b0, word_ready_o}, 64'd1);
        check("rst_held_idx", 64'(fill_idx_o), 64'd0);
        @(posedge clk);
        #1;

        // A clean frame after reset, then drain the scoreboard
        good_frame(64'hA000);
        drain();
        check("scoreboard_empty", exp_q.size(), 0);
        check("err_pulse_total", err_pulses, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
